draw_cursor_overlay: RTL

- Parametrised cursor overlay stage in the VGA chain; sits after the board/ship drawing stages, before the output register to the connector.
- Selectable cursor modes: hidden, bitmap arrow, crosshair, ship-placement ghost (horizontal/vertical, with a blinking "illegal placement" indication).
- Cursor state is sampled once per frame, at vblank start, so the cursor cannot tear.
- Delay-matched pipeline for all timing signals.

---
 rtl/draw_cursor_overlay_if.sv | 21 ++
 rtl/draw_cursor_overlay.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_cursor_overlay_if.sv
// VGA raster bundle carried between drawing stages: pixel position,
// sync pulses, blanking flags and 12-bit colour.
interface vga_if;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   // Source side of a link: the stage that drives the raster.
   modport out (
      output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
   );

   // Sink side of a link: the stage that consumes the raster.
   modport in (
      input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
   );
endinterface

// File: rtl/draw_cursor_overlay.sv
// Cursor overlay stage for the VGA chain. Draws a bitmap arrow, a crosshair
// or a ship-placement ghost on top of the incoming raster. Cursor state is
// captured once per frame at the start of vertical blanking, so a cursor
// never tears. Every raster field leaves exactly two clocks after it arrives.
module draw_cursor_overlay #(
   parameter int          SPRITE_W     = 16,
   parameter int          SPRITE_H     = 16,
   parameter int          CROSS_R      = 8,
   parameter int          CELL         = 32,
   parameter int          MAX_LEN      = 4,
   parameter int          BLINK_FRAMES = 15,
   parameter logic [11:0] COL_BLACK    = 12'h000,
   parameter logic [11:0] COL_WHITE    = 12'hFFF,
   parameter logic [11:0] COL_OK       = 12'h0F0,
   parameter logic [11:0] COL_BAD      = 12'hF00
) (
   input  logic                         clk,
   input  logic                         rst_n,
   vga_if.in                            vga_in,
   vga_if.out                           vga_out,
   input  logic [11:0]                  xpos,
   input  logic [11:0]                  ypos,
   input  logic [1:0]                   mode,
   input  logic [$clog2(MAX_LEN+1)-1:0] ship_len,
   input  logic                         vertical,
   input  logic                         placement_ok
);

   localparam int LEN_W  = $clog2(MAX_LEN + 1);
   localparam int CNT_W  = $clog2(BLINK_FRAMES + 1);
   localparam int ROM_N  = SPRITE_W * SPRITE_H;
   localparam int ADDR_W = $clog2(ROM_N);
   localparam int EDGE   = 2;                 // ghost outline thickness
   localparam int HEAD_H = (SPRITE_H * 3) / 4; // rows taken by the arrow head
   localparam int TAIL_X = SPRITE_W / 4;       // left column of the 3-wide tail

   typedef enum logic [1:0] {
      MODE_HIDDEN = 2'b00,
      MODE_ARROW  = 2'b01,
      MODE_CROSS  = 2'b10,
      MODE_GHOST  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      PX_CLEAR = 2'd0,
      PX_BLACK = 2'd1,
      PX_WHITE = 2'd2,
      PX_RSVD  = 2'd3
   } px_t;

   typedef struct packed {
      logic [11:0] hcount;
      logic [11:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } raster_t;

   // Arrow bitmap: a right-triangle head with a black outline and white
   // fill, tip at (0,0), followed by a short three-pixel-wide tail.
   function automatic logic [2*ROM_N-1:0] build_rom();
      logic [2*ROM_N-1:0] bits;
      px_t                code;
      bits = '0;
      for (int r = 0; r < SPRITE_H; r++) begin
         for (int c = 0; c < SPRITE_W; c++) begin
            code = PX_CLEAR;
            if (r < HEAD_H) begin
               if (c <= r) begin
                  if (c == 0 || c == r || r == HEAD_H - 1) code = PX_BLACK;
                  else                                     code = PX_WHITE;
               end
            end else if (c >= TAIL_X && c <= TAIL_X + 2) begin
               if (c == TAIL_X || c == TAIL_X + 2 || r == SPRITE_H - 1) code = PX_BLACK;
               else                                                     code = PX_WHITE;
            end
            bits[2*(r*SPRITE_W+c) +: 2] = code;
         end
      end
      return bits;
   endfunction

   localparam logic [2*ROM_N-1:0] ROM_BITS = build_rom();

   // Per-frame cursor snapshot and blink state.
   logic              vblnk_d;
   logic              vblnk_rise;
   logic [11:0]       x_s;
   logic [11:0]       y_s;
   mode_t             mode_s;
   logic [LEN_W-1:0]  len_s;
   logic              vert_s;
   logic              ok_s;
   logic [CNT_W-1:0]  frame_cnt;
   logic              blink_phase;

   // Stage-1 combinational results.
   raster_t           in_r;
   logic signed [12:0] dx13;
   logic signed [12:0] dy13;
   int                dx;
   int                dy;
   int                adx;
   int                ady;
   int                ghost_l;
   int                ghost_w;
   int                ghost_h;
   logic              arrow_in;
   logic              cross_hit;
   logic              ghost_in;
   logic              ghost_edge;
   logic              paint;
   logic [11:0]       paint_col;
   logic [ADDR_W-1:0] rom_addr;

   // Stage-1 registers.
   raster_t           s1_r;
   logic              s1_arrow;
   logic              s1_paint;
   logic [11:0]       s1_col;
   px_t               rom_q;

   // Stage-2 combinational colour and output register.
   logic [11:0]       rgb_next;
   raster_t           out_r;

   assign in_r = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync,
                  vga_in.hblnk, vga_in.vblnk, vga_in.rgb};

   assign vblnk_rise = vga_in.vblnk & ~vblnk_d;

   // Capture cursor inputs and advance the blink counter at vblank start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vblnk_d     <= 1'b0;
         x_s         <= '0;
         y_s         <= '0;
         mode_s      <= MODE_HIDDEN;
         len_s       <= '0;
         vert_s      <= 1'b0;
         ok_s        <= 1'b1;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register in this block
         // sample the pre-edge values, so x_s and vblnk_d update together.
         vblnk_d <= vga_in.vblnk;
         if (vblnk_rise) begin
            x_s    <= xpos;
            y_s    <= ypos;
            mode_s <= mode_t'(mode);
            len_s  <= ship_len;
            vert_s <= vertical;
            ok_s   <= placement_ok;
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Offsets from the hotspot, hit tests for each cursor shape, ROM address.
   always_comb begin
      // NOTE: every output of this block is given a value before any branch,
      // otherwise paths that skip an assignment would infer latches.
      paint     = 1'b0;
      paint_col = COL_WHITE;
      rom_addr  = '0;

      dx13 = $signed({1'b0, vga_in.hcount}) - $signed({1'b0, x_s});
      dy13 = $signed({1'b0, vga_in.vcount}) - $signed({1'b0, y_s});
      dx   = int'(dx13);
      dy   = int'(dy13);
      adx  = (dx < 0) ? -dx : dx;
      ady  = (dy < 0) ? -dy : dy;

      arrow_in = (mode_s == MODE_ARROW) &&
                 (dx >= 0) && (dx < SPRITE_W) && (dy >= 0) && (dy < SPRITE_H);
      if (arrow_in) rom_addr = ADDR_W'(dy * SPRITE_W + dx);

      cross_hit = (mode_s == MODE_CROSS) &&
                  (((dx == 0) && (ady <= CROSS_R)) || ((dy == 0) && (adx <= CROSS_R)));

      // Lengths beyond MAX_LEN are clamped; length 0 gives an empty box.
      ghost_l    = (int'(len_s) > MAX_LEN) ? MAX_LEN : int'(len_s);
      ghost_w    = vert_s ? CELL : ghost_l * CELL;
      ghost_h    = vert_s ? ghost_l * CELL : CELL;
      ghost_in   = (mode_s == MODE_GHOST) &&
                   (dx >= 0) && (dx < ghost_w) && (dy >= 0) && (dy < ghost_h);
      ghost_edge = (dx < EDGE) || (dx >= ghost_w - EDGE) ||
                   (dy < EDGE) || (dy >= ghost_h - EDGE);

      if (cross_hit) begin
         paint     = 1'b1;
         paint_col = COL_WHITE;
      end else if (ghost_in && ghost_edge) begin
         if (ok_s) begin
            paint     = 1'b1;
            paint_col = COL_OK;
         end else if (blink_phase) begin
            paint     = 1'b1;
            paint_col = COL_BAD;
         end
      end
   end

   // Stage 1: hold the raster and the per-pixel overlay decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r     <= '0;
         s1_arrow <= 1'b0;
         s1_paint <= 1'b0;
         s1_col   <= '0;
      end else begin
         s1_r     <= in_r;
         s1_arrow <= arrow_in;
         s1_paint <= paint;
         s1_col   <= paint_col;
      end
   end

   // Synchronous arrow ROM read, aligned with stage 1.
   always_ff @(posedge clk) begin
      // NOTE: the ROM output register has no reset; it is only consulted
      // when s1_arrow is set, and s1_arrow itself is reset.
      rom_q <= px_t'(ROM_BITS[{rom_addr, 1'b0} +: 2]);
   end

   // Final colour: blanking forces black, otherwise overlay or pass-through.
   always_comb begin
      rgb_next = s1_r.rgb;
      if (s1_r.hblnk || s1_r.vblnk) begin
         rgb_next = 12'h000;
      end else if (s1_paint) begin
         rgb_next = s1_col;
      end else if (s1_arrow) begin
         case (rom_q)
            PX_BLACK: rgb_next = COL_BLACK;
            PX_WHITE: rgb_next = COL_WHITE;
            default:  rgb_next = s1_r.rgb;
         endcase
      end
   end

   // Stage 2: output register toward the connector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r <= '0;
      end else begin
         out_r     <= s1_r;
         out_r.rgb <= rgb_next;
      end
   end

   assign vga_out.hcount = out_r.hcount;
   assign vga_out.vcount = out_r.vcount;
   assign vga_out.hsync  = out_r.hsync;
   assign vga_out.vsync  = out_r.vsync;
   assign vga_out.hblnk  = out_r.hblnk;
   assign vga_out.vblnk  = out_r.vblnk;
   assign vga_out.rgb    = out_r.rgb;

endmodule
